// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared constants and helpers for the LED scheduler.
//   - FSM state encoding (STATE_IDLE / STATE_HOLD)
//   - LED_OFF: active-low "all LEDs dark" pattern
//   - NUM_REQ: number of status requesters
//   - Round-robin search and one-hot/index conversion helpers
package led_sched_pkg;

   localparam int unsigned NUM_REQ = 3;

   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_HOLD = 1'b1;

   localparam logic [3:0] LED_OFF = 4'hF;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } pick_t;

   // Next requester index mod 3; a stray value of 3 folds back to 0.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // First requester at or after ptr (ptr, ptr+1, ptr+2 mod 3).
   function automatic pick_t rr_pick(input logic [2:0] req, input logic [1:0] ptr);
      logic [1:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      pick_t      p;
      c0 = (ptr == 2'd3) ? 2'd0 : ptr;
      c1 = rr_next(c0);
      c2 = rr_next(c1);
      p.valid = 1'b1;
      if (req[c0]) begin
         p.idx = c0;
      end else if (req[c1]) begin
         p.idx = c1;
      end else if (req[c2]) begin
         p.idx = c2;
      end else begin
         p.valid = 1'b0;
         p.idx   = 2'd0;
      end
      return p;
   endfunction

   function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b001;
      endcase
      return oh;
   endfunction

   // Owner index of a one-hot grant; idle (all zero) maps to 0.
   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      logic [1:0] idx;
      case (oh)
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [3:0] code_of(input logic [11:0] code, input logic [1:0] idx);
      logic [3:0] c;
      case (idx)
         2'd1:    c = code[7:4];
         2'd2:    c = code[11:8];
         default: c = code[3:0];
      endcase
      return c;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running prescaler producing a one-cycle tick pulse.
//   clk    in  system clock
//   rst_in in  asynchronous active-high reset
//   tick   out registered pulse, high for one clk every TICK_DIV clks
// The counter runs 0..TICK_DIV-1; tick is high in the cycle after the
// counter sits at TICK_DIV-1.
module led_tick_gen #(
   parameter logic [26:0] TICK_DIV = 27'd20_000_000
) (
   input  logic clk,
   input  logic rst_in,
   output logic tick
);

   localparam logic [26:0] TERM = TICK_DIV - 27'd1;

   logic [26:0] cnt_q, cnt_d;
   logic        tick_q, tick_d;

   always_comb begin
      tick_d = (cnt_q == TERM);
      cnt_d  = (cnt_q == TERM) ? 27'd0 : cnt_q + 27'd1;
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         cnt_q  <= 27'd0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/led_sched.sv
// led_sched: time-shares four active-low LEDs among three status requesters.
//   clk    in  system clock
//   rst_in in  asynchronous active-high reset
//   req    in  per-requester level request
//   code   in  code[4i+3:4i] = active-high pattern of requester i
//   blink  in  blink[i] = blink requester i's pattern at tick rate
//   grant  out one-hot current owner, 0 when idle
//   tick   out one-cycle prescaler pulse
//   leds   out active-low LED drive
// Round-robin arbitration; each grant is held for at least DWELL_TICKS ticks.
module led_sched
   import led_sched_pkg::*;
#(
   parameter logic [26:0] TICK_DIV    = 27'd20_000_000,
   parameter logic [3:0]  DWELL_TICKS = 4'd5
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [4*NUM_REQ-1:0]   code,
   input  logic [NUM_REQ-1:0]     blink,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   tick,
   output logic [3:0]             leds
);

   logic       tick_w;

   logic       state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [3:0] shown_q, shown_d;
   logic [3:0] dwell_q, dwell_d;
   logic       phase_q, phase_d;
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0] leds_q, leds_d;

   logic [1:0] owner;
   logic [1:0] owner_d;
   logic [1:0] rel_ptr;
   pick_t      idle_pick;
   pick_t      rel_pick;
   logic [2:0] others;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_in (rst_in),
      .tick   (tick_w)
   );

   assign owner     = onehot_to_idx(grant_q);
   assign rel_ptr   = rr_next(owner);
   assign idle_pick = rr_pick(req, rr_ptr_q);
   // Search starts after the owner, so the owner is only re-picked last.
   assign rel_pick  = rr_pick(req, rel_ptr);
   assign others    = req & ~grant_q;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      shown_d  = shown_q;
      dwell_d  = dwell_q;
      phase_d  = phase_q;
      rr_ptr_d = rr_ptr_q;

      if (state_q == STATE_IDLE) begin
         if (idle_pick.valid) begin
            state_d = STATE_HOLD;
            grant_d = idx_to_onehot(idle_pick.idx);
            shown_d = code_of(code, idle_pick.idx);
            dwell_d = DWELL_TICKS;
            phase_d = 1'b1;
         end
      end else begin
         // Display tracks the owner's code only while it still requests.
         if (req[owner]) begin
            shown_d = code_of(code, owner);
         end
         if (tick_w) begin
            if (blink[owner]) begin
               phase_d = ~phase_q;
            end
            if (dwell_q != 4'd0) begin
               dwell_d = dwell_q - 4'd1;
            end
            if (dwell_q == 4'd1) begin
               if (|others) begin
                  rr_ptr_d = rel_ptr;
                  grant_d  = idx_to_onehot(rel_pick.idx);
                  shown_d  = code_of(code, rel_pick.idx);
                  dwell_d  = DWELL_TICKS;
                  phase_d  = 1'b1;
               end else if (req[owner]) begin
                  // Sole requester keeps the LEDs; blink phase runs on.
                  dwell_d = DWELL_TICKS;
               end else begin
                  state_d  = STATE_IDLE;
                  grant_d  = 3'b000;
                  rr_ptr_d = rel_ptr;
               end
            end
         end
      end
   end

   // LEDs are registered from next-state values so they move with grant.
   always_comb begin
      owner_d = onehot_to_idx(grant_d);
      leds_d  = LED_OFF;
      if (state_d == STATE_HOLD) begin
         if (blink[owner_d]) begin
            leds_d = ~(shown_d & {4{phase_d}});
         end else begin
            leds_d = ~shown_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= STATE_IDLE;
         grant_q  <= 3'b000;
         shown_q  <= 4'h0;
         dwell_q  <= 4'h0;
         phase_q  <= 1'b1;
         rr_ptr_q <= 2'd0;
         leds_q   <= LED_OFF;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         shown_q  <= shown_d;
         dwell_q  <= dwell_d;
         phase_q  <= phase_d;
         rr_ptr_q <= rr_ptr_d;
         leds_q   <= leds_d;
      end
   end

   assign grant = grant_q;
   assign leds  = leds_q;
   assign tick  = tick_w;

endmodule

// File: tb/tb_led_sched.sv
// tb_led_sched: directed self-checking bench for led_sched with
// TICK_DIV = 4 and DWELL_TICKS = 2.
module tb_led_sched;

   logic        clk;
   logic        rst_in;
   logic [2:0]  req;
   logic [11:0] code;
   logic [2:0]  blink;
   logic [2:0]  grant;
   logic        tick;
   logic [3:0]  leds;

   int n_cmp = 0;
   int n_err = 0;

   led_sched #(
      .TICK_DIV    (27'd4),
      .DWELL_TICKS (4'd2)
   ) dut (
      .clk    (clk),
      .rst_in (rst_in),
      .req    (req),
      .code   (code),
      .blink  (blink),
      .grant  (grant),
      .tick   (tick),
      .leds   (leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reset pulse spanning two edges; released 1 time unit after an edge.
   task automatic do_reset();
      rst_in = 1'b1;
      cyc(2);
      rst_in = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1;
      req    = 3'b000;
      code   = 12'h000;
      blink  = 3'b000;

      // 1: reset state and tick period
      cyc(2);
      check("rst_leds", leds, 4'hF);
      check("rst_grant", {1'b0, grant}, 4'h0);
      check("rst_tick", {3'b0, tick}, 4'h0);
      rst_in = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         cyc(1);
         check($sformatf("tick_p%0d", n), {3'b0, tick}, (n % 4 == 0) ? 4'h1 : 4'h0);
      end
      check("idle_leds", leds, 4'hF);
      check("idle_grant", {1'b0, grant}, 4'h0);

      // 2: single requester, dwell after req drop (tick seen at P17, P21)
      req  = 3'b001;
      code = 12'h00A;
      cyc(1);
      check("t2_grant", {1'b0, grant}, 4'b0001);
      check("t2_leds", leds, 4'h5);
      req = 3'b000;
      cyc(4);
      check("t2_hold_leds_p17", leds, 4'h5);
      check("t2_hold_grant_p17", {1'b0, grant}, 4'b0001);
      cyc(3);
      check("t2_hold_leds_p20", leds, 4'h5);
      cyc(1);
      check("t2_rel_leds", leds, 4'hF);
      check("t2_rel_grant", {1'b0, grant}, 4'h0);
      // rr_ptr advanced to 1, so requester 2 beats requester 0
      req  = 3'b101;
      code = 12'h80A;
      cyc(1);
      check("rr_grant", {1'b0, grant}, 4'b0100);
      check("rr_leds", leds, 4'h7);

      // 3: three-way round robin held from reset
      req  = 3'b111;
      code = 12'h421;
      do_reset();
      cyc(1);
      check("rr3_g0", {1'b0, grant}, 4'b0001);
      check("rr3_l0", leds, 4'hE);
      cyc(7);
      check("rr3_g0_end", {1'b0, grant}, 4'b0001);
      cyc(1);
      check("rr3_g1", {1'b0, grant}, 4'b0010);
      check("rr3_l1", leds, 4'hD);
      cyc(7);
      check("rr3_g1_end", {1'b0, grant}, 4'b0010);
      cyc(1);
      check("rr3_g2", {1'b0, grant}, 4'b0100);
      check("rr3_l2", leds, 4'hB);
      cyc(7);
      check("rr3_g2_end", {1'b0, grant}, 4'b0100);
      cyc(1);
      check("rr3_wrap_g", {1'b0, grant}, 4'b0001);
      check("rr3_wrap_l", leds, 4'hE);

      // 4: blink, sole requester keeps LEDs across dwell reload
      req   = 3'b001;
      code  = 12'h42F;
      blink = 3'b001;
      do_reset();
      cyc(1);
      check("blk_q1", leds, 4'h0);
      cyc(3);
      check("blk_q4", leds, 4'h0);
      cyc(1);
      check("blk_q5", leds, 4'hF);
      cyc(3);
      check("blk_q8", leds, 4'hF);
      cyc(1);
      check("blk_q9", leds, 4'h0);
      check("blk_q9_grant", {1'b0, grant}, 4'b0001);
      cyc(4);
      check("blk_q13", leds, 4'hF);

      // 5: code tracking mid-grant
      blink = 3'b000;
      code  = 12'h423;
      cyc(1);
      check("trk_3", leds, 4'hC);
      code = 12'h42C;
      cyc(1);
      check("trk_C", leds, 4'h3);

      // 6: asynchronous reset mid-HOLD
      req  = 3'b010;
      code = 12'h461;
      do_reset();
      cyc(1);
      check("ar_pre_grant", {1'b0, grant}, 4'b0010);
      check("ar_pre_leds", leds, 4'h9);
      #3;
      rst_in = 1'b1;
      #1;
      check("ar_leds", leds, 4'hF);
      check("ar_grant", {1'b0, grant}, 4'h0);
      check("ar_tick", {3'b0, tick}, 4'h0);
      req  = 3'b111;
      code = 12'h421;
      cyc(2);
      rst_in = 1'b0;
      cyc(1);
      check("ar_tie_grant", {1'b0, grant}, 4'b0001);
      check("ar_tie_leds", leds, 4'hE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
